// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: game FSM, movement tick generator,
// direction latch with reversal rejection and apple growth events.
module snake_game_ctrl #(
    parameter int TICK_DIV   = 4777778,
    parameter int MIN_DIV    = 1000000,
    parameter int SPEED_STEP = 100000,
    parameter int MAX_LEN    = 127,
    parameter int CNT_W      = 24
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       key_valid,
    input  logic [7:0] key_code,
    input  logic       good_collision,
    input  logic       bad_collision,
    output logic       update_tick,
    output logic [1:0] direction,
    output logic       game_init,
    output logic       game_over,
    output logic [1:0] state,
    output logic [6:0] size,
    output logic [6:0] score,
    output logic       grow,
    output logic       apple_respawn
);

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] RUN   = 2'b01;
    localparam logic [1:0] PAUSE = 2'b10;
    localparam logic [1:0] OVER  = 2'b11;

    localparam logic [CNT_W-1:0] PERIOD_INIT = CNT_W'(TICK_DIV);
    localparam logic [CNT_W:0]   MIN_X       = (CNT_W+1)'(MIN_DIV);
    localparam logic [CNT_W:0]   STEP_X      = (CNT_W+1)'(SPEED_STEP);
    localparam logic [6:0]       LEN_MAX     = 7'(MAX_LEN);

    logic [1:0]       next_dir;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] tick_cnt;
    logic             good_prev;

    logic             esc;
    logic             dir_key;
    logic [1:0]       key_dir;
    logic             run_ok;
    logic             grow_ok;
    logic             tick_hit;
    logic [CNT_W:0]   period_x;
    logic [CNT_W-1:0] period_dec;
    logic [1:0]       state_nxt;

    always_comb begin
        dir_key = 1'b0;
        key_dir = 2'b00;
        esc     = 1'b0;
        if (key_valid) begin
            case (key_code)
                8'h1D: begin dir_key = 1'b1; key_dir = 2'b00; end
                8'h1B: begin dir_key = 1'b1; key_dir = 2'b01; end
                8'h1C: begin dir_key = 1'b1; key_dir = 2'b10; end
                8'h23: begin dir_key = 1'b1; key_dir = 2'b11; end
                8'h76: esc = 1'b1;
                default: ;
            endcase
        end
    end

    assign run_ok   = (state == RUN) && !bad_collision;
    assign grow_ok  = run_ok && good_collision && !good_prev;
    // >= rather than == so a shortened period fires at once
    assign tick_hit = tick_cnt >= (period - CNT_W'(1));
    assign period_x = {1'b0, period};

    always_comb begin
        if (period_x >= MIN_X + STEP_X) begin
            period_dec = CNT_W'(period_x - STEP_X);
        end else begin
            period_dec = CNT_W'(MIN_X);
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (start) state_nxt = RUN;
            RUN: begin
                if (bad_collision) state_nxt = OVER;
                else if (esc)      state_nxt = PAUSE;
            end
            PAUSE: begin
                if (esc)        state_nxt = RUN;
                else if (start) state_nxt = IDLE;
            end
            OVER:  if (start) state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            direction     <= 2'b11;
            next_dir      <= 2'b11;
            size          <= 7'd1;
            score         <= 7'd0;
            period        <= PERIOD_INIT;
            tick_cnt      <= '0;
            update_tick   <= 1'b0;
            grow          <= 1'b0;
            apple_respawn <= 1'b0;
            game_init     <= 1'b1;
            game_over     <= 1'b0;
            good_prev     <= 1'b0;
        end else begin
            state         <= state_nxt;
            game_init     <= (state_nxt == IDLE);
            game_over     <= (state_nxt == OVER);
            good_prev     <= good_collision;
            update_tick   <= 1'b0;
            grow          <= grow_ok;
            apple_respawn <= grow;

            if (run_ok && !esc) begin
                if (tick_hit) begin
                    tick_cnt    <= '0;
                    update_tick <= 1'b1;
                    direction   <= next_dir;
                end else begin
                    tick_cnt <= tick_cnt + CNT_W'(1);
                end
                if (dir_key && (key_dir != (direction ^ 2'b01))) begin
                    next_dir <= key_dir;
                end
            end

            if (grow_ok) begin
                if (size < LEN_MAX)  size  <= size + 7'd1;
                if (score < LEN_MAX) score <= score + 7'd1;
                period <= period_dec;
            end

            // Entering or sitting in IDLE restores the start-of-game values
            if (state_nxt == IDLE) begin
                direction <= 2'b11;
                next_dir  <= 2'b11;
                size      <= 7'd1;
                score     <= 7'd0;
                period    <= PERIOD_INIT;
                tick_cnt  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Scoreboard bench for snake_game_ctrl: stimulus queues expected
// pulses and status snapshots, a negedge monitor pops and compares.
module tb_snake_game_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       key_valid = 1'b0;
    logic [7:0] key_code = 8'h00;
    logic       good_collision = 1'b0;
    logic       bad_collision = 1'b0;
    logic       update_tick;
    logic [1:0] direction;
    logic       game_init;
    logic       game_over;
    logic [1:0] state;
    logic [6:0] size;
    logic [6:0] score;
    logic       grow;
    logic       apple_respawn;

    snake_game_ctrl #(
        .TICK_DIV(8), .MIN_DIV(4), .SPEED_STEP(2), .MAX_LEN(4), .CNT_W(8)
    ) dut (
        .clock(clock), .reset(reset), .start(start),
        .key_valid(key_valid), .key_code(key_code),
        .good_collision(good_collision), .bad_collision(bad_collision),
        .update_tick(update_tick), .direction(direction),
        .game_init(game_init), .game_over(game_over), .state(state),
        .size(size), .score(score), .grow(grow),
        .apple_respawn(apple_respawn)
    );

    always #5 clock = ~clock;

    typedef struct { int c; logic [1:0] d; } tick_t;
    typedef struct { int c; logic [6:0] sz; logic [6:0] sc; } grow_t;
    typedef struct {
        int c; logic [1:0] st; logic [6:0] sz; logic [6:0] sc; logic [1:0] d;
    } st_t;

    tick_t tick_q[$];
    grow_t grow_q[$];
    int    resp_q[$];
    st_t   st_q[$];

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    bit done = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic at(input int c);
        while (cyc < c) step();
    endtask

    task automatic exp_tick(input int c, input logic [1:0] d);
        tick_t t;
        t.c = c; t.d = d;
        tick_q.push_back(t);
    endtask

    task automatic exp_grow(input int c, input logic [6:0] sz,
                            input logic [6:0] sc);
        grow_t g;
        g.c = c; g.sz = sz; g.sc = sc;
        grow_q.push_back(g);
        resp_q.push_back(c + 1);
    endtask

    task automatic exp_st(input int c, input logic [1:0] st,
                          input logic [6:0] sz, input logic [6:0] sc,
                          input logic [1:0] d);
        st_t s;
        s.c = c; s.st = st; s.sz = sz; s.sc = sc; s.d = d;
        st_q.push_back(s);
    endtask

    always @(negedge clock) begin
        if (update_tick) begin
            checks++;
            if (tick_q.size() == 0) begin
                failures++;
                $display("FAIL tick: unexpected pulse at cyc=%0d dir=%b", cyc, direction);
            end else begin
                tick_t t;
                t = tick_q.pop_front();
                if (t.c != cyc || t.d != direction) begin
                    failures++;
                    $display("FAIL tick: got cyc=%0d dir=%b want cyc=%0d dir=%b",
                             cyc, direction, t.c, t.d);
                end
            end
        end
        if (grow) begin
            checks++;
            if (grow_q.size() == 0) begin
                failures++;
                $display("FAIL grow: unexpected pulse at cyc=%0d", cyc);
            end else begin
                grow_t g;
                g = grow_q.pop_front();
                if (g.c != cyc || g.sz != size || g.sc != score) begin
                    failures++;
                    $display("FAIL grow: got cyc=%0d size=%0d score=%0d want cyc=%0d size=%0d score=%0d",
                             cyc, size, score, g.c, g.sz, g.sc);
                end
            end
        end
        if (apple_respawn) begin
            checks++;
            if (resp_q.size() == 0) begin
                failures++;
                $display("FAIL respawn: unexpected pulse at cyc=%0d", cyc);
            end else begin
                int rc;
                rc = resp_q.pop_front();
                if (rc != cyc) begin
                    failures++;
                    $display("FAIL respawn: got cyc=%0d want cyc=%0d", cyc, rc);
                end
            end
        end
        while (st_q.size() > 0 && st_q[0].c <= cyc) begin
            st_t s;
            s = st_q.pop_front();
            checks++;
            if (s.c != cyc || s.st != state || s.sz != size || s.sc != score ||
                s.d != direction || game_init != (s.st == 2'b00) ||
                game_over != (s.st == 2'b11)) begin
                failures++;
                $display("FAIL status@%0d: got cyc=%0d st=%b size=%0d score=%0d dir=%b init=%b over=%b want st=%b size=%0d score=%0d dir=%b",
                         s.c, cyc, state, size, score, direction, game_init,
                         game_over, s.st, s.sz, s.sc, s.d);
            end
        end
        if (done) begin
            checks++;
            if (tick_q.size() + grow_q.size() + resp_q.size() + st_q.size() != 0) begin
                failures++;
                $display("FAIL leftover: got ticks=%0d grows=%0d resp=%0d status=%0d pending want 0",
                         tick_q.size(), grow_q.size(), resp_q.size(), st_q.size());
            end
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int r;
        int p;
        exp_st(2, 2'b00, 7'd1, 7'd0, 2'b11);
        step(); step();
        reset = 1'b0;

        // Start and first ticks, then direction keys
        r = 4;
        exp_st(r, 2'b01, 7'd1, 7'd0, 2'b11);
        exp_tick(r + 8, 2'b11);
        exp_tick(r + 16, 2'b01);
        exp_tick(r + 24, 2'b01);
        exp_tick(r + 32, 2'b10);
        exp_tick(r + 40, 2'b10);
        at(3); start = 1'b1;
        at(r); start = 1'b0;
        at(r + 8);  key_valid = 1'b1; key_code = 8'h1C;
        at(r + 9);  key_code = 8'h1D;
        at(r + 10); key_code = 8'h1B;
        at(r + 11); key_valid = 1'b0;
        at(r + 17); key_valid = 1'b1; key_code = 8'h1D;
        at(r + 18); key_code = 8'h55;
        at(r + 19); key_valid = 1'b0;
        at(r + 24); key_valid = 1'b1; key_code = 8'h1C;
        at(r + 25); key_valid = 1'b0;
        at(r + 32); key_valid = 1'b1; key_code = 8'h23;
        at(r + 33); key_valid = 1'b0;

        // Growth, speed-up, clamp and saturation
        exp_grow(r + 43, 7'd2, 7'd1);
        exp_tick(r + 46, 2'b10);
        exp_tick(r + 52, 2'b10);
        exp_tick(r + 58, 2'b10);
        exp_tick(r + 64, 2'b10);
        exp_grow(r + 66, 7'd3, 7'd2);
        exp_tick(r + 68, 2'b10);
        exp_grow(r + 70, 7'd4, 7'd3);
        exp_tick(r + 72, 2'b10);
        exp_grow(r + 74, 7'd4, 7'd4);
        exp_tick(r + 76, 2'b10);
        exp_grow(r + 78, 7'd4, 7'd4);
        exp_st(r + 79, 2'b01, 7'd4, 7'd4, 2'b10);
        exp_tick(r + 80, 2'b10);
        exp_tick(r + 84, 2'b10);
        at(r + 42); good_collision = 1'b1;
        at(r + 62); good_collision = 1'b0;
        for (int k = 0; k < 4; k++) begin
            at(r + 65 + 4 * k); good_collision = 1'b1;
            at(r + 66 + 4 * k); good_collision = 1'b0;
        end

        // Simultaneous good/bad collision ends the game
        exp_st(r + 86, 2'b11, 7'd4, 7'd4, 2'b10);
        exp_st(r + 95, 2'b11, 7'd4, 7'd4, 2'b10);
        exp_st(r + 97, 2'b00, 7'd1, 7'd0, 2'b11);
        at(r + 85); good_collision = 1'b1; bad_collision = 1'b1;
        at(r + 88); good_collision = 1'b0; bad_collision = 1'b0;
        at(r + 90); key_valid = 1'b1; key_code = 8'h76;
        at(r + 91); key_valid = 1'b0;
        at(r + 92); good_collision = 1'b1;
        at(r + 93); good_collision = 1'b0;
        at(r + 96); start = 1'b1;
        at(r + 97); start = 1'b0;

        // Pause at tick_cnt=5, resume, then reset mid-run
        p = r + 99;
        exp_tick(p + 8, 2'b11);
        exp_st(p + 14, 2'b10, 7'd1, 7'd0, 2'b11);
        exp_st(p + 40, 2'b10, 7'd1, 7'd0, 2'b11);
        exp_tick(p + 67, 2'b11);
        exp_grow(p + 69, 7'd2, 7'd1);
        exp_tick(p + 73, 2'b01);
        exp_grow(p + 77, 7'd3, 7'd2);
        exp_tick(p + 78, 2'b01);
        exp_st(p + 80, 2'b00, 7'd1, 7'd0, 2'b11);
        exp_st(p + 85, 2'b00, 7'd1, 7'd0, 2'b11);
        at(r + 98); start = 1'b1;
        at(p);      start = 1'b0;
        at(p + 13); key_valid = 1'b1; key_code = 8'h76;
        at(p + 14); key_valid = 1'b0;
        at(p + 20); key_valid = 1'b1; key_code = 8'h1D;
        at(p + 21); key_valid = 1'b0;
        at(p + 30); good_collision = 1'b1;
        at(p + 31); good_collision = 1'b0;
        at(p + 63); key_valid = 1'b1; key_code = 8'h76;
        at(p + 64); key_valid = 1'b0;
        at(p + 67); key_valid = 1'b1; key_code = 8'h1B;
        at(p + 68); key_valid = 1'b0; good_collision = 1'b1;
        at(p + 69); good_collision = 1'b0;
        at(p + 76); good_collision = 1'b1;
        at(p + 77); good_collision = 1'b0;
        at(p + 80); reset = 1'b1;
        at(p + 82); reset = 1'b0;
        at(p + 90);
        done = 1'b1;
    end

endmodule
